// File: rtl/branch_predict_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_predict_ctrl
// Purpose  : Branch decision stage paired with the BTB. Holds a BHT of 2-bit
//            saturating counters, forms the IF-stage next PC from the BTB
//            hit/target and the BHT direction, carries each prediction down
//            to EX and resolves it there (mispredict flush, corrected PC,
//            BTB write strobe).
// Options  : define BP_STATS_EN to add the branch_cnt / mispredict_cnt
//            statistics outputs.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predict_ctrl #(
  parameter int unsigned BHT_ADDR_LEN = 7,
  parameter logic [1:0]  CNT_RESET    = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  // IF stage
  input  logic [31:0] PC_IF,
  input  logic        isHit_BTB,
  input  logic [31:0] predictedPC,
  output logic [31:0] NPC_pred,
  output logic        predTaken_IF,
  // pipeline control
  input  logic        en_IFID,
  input  logic        flush_IFID,
  input  logic        en_IDEX,
  input  logic        flush_IDEX,
  input  logic        en_EXMEM,
  // EX stage
  input  logic        isBranch_EX,
  input  logic        isTakenBr_Ex,
  input  logic [31:0] PC_EX,
  input  logic [31:0] PC_Branch,
  output logic        flush_mispredict,
  output logic [31:0] PC_correct,
  output logic        btb_wr_req
`ifdef BP_STATS_EN
  ,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispredict_cnt
`endif
);

  localparam int         BHT_ENTRIES = 1 << BHT_ADDR_LEN;
  localparam logic [1:0] CNT_MAX     = 2'b11;
  localparam logic [1:0] CNT_MIN     = 2'b00;

  // --------------------------------------------------------------------------
  // Branch history table
  // --------------------------------------------------------------------------
  logic [1:0]              bht_q [BHT_ENTRIES];
  logic [1:0]              cnt_d;
  logic [BHT_ADDR_LEN-1:0] w_if_idx;
  logic [BHT_ADDR_LEN-1:0] w_ex_idx;
  logic [1:0]              w_ex_cnt;
  logic                    w_bht_upd;

  assign w_if_idx  = PC_IF[BHT_ADDR_LEN+1:2];
  assign w_ex_idx  = PC_EX[BHT_ADDR_LEN+1:2];
  assign w_ex_cnt  = bht_q[w_ex_idx];
  // A stalled EX instruction must not train the table, otherwise one branch
  // would be counted once per stall cycle.
  assign w_bht_upd = isBranch_EX & en_EXMEM;

  // Saturating step of the counter addressed by the retiring branch.
  always_comb begin
    cnt_d = w_ex_cnt;
    if (isTakenBr_Ex) begin
      if (w_ex_cnt != CNT_MAX) cnt_d = w_ex_cnt + 2'd1;
    end else begin
      if (w_ex_cnt != CNT_MIN) cnt_d = w_ex_cnt - 2'd1;
    end
  end

  // Table storage: reset to weakly-not-taken, written once per retiring branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= CNT_RESET;
      end
    end else if (w_bht_upd) begin
      bht_q[w_ex_idx] <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // IF stage: direction from the counter MSB, qualified by a BTB hit. The
  // table read uses the registered contents, so an update to the same index
  // in this cycle is seen only from the next cycle on.
  // --------------------------------------------------------------------------
  assign predTaken_IF = isHit_BTB & bht_q[w_if_idx][1];
  assign NPC_pred     = predTaken_IF ? predictedPC : (PC_IF + 32'd4);

  // --------------------------------------------------------------------------
  // Prediction tracking IF -> ID -> EX
  // --------------------------------------------------------------------------
  logic        pred_id_q, pred_id_d;
  logic [31:0] tgt_id_q,  tgt_id_d;
  logic        pred_ex_q, pred_ex_d;
  logic [31:0] tgt_ex_q,  tgt_ex_d;

  // Next state of the tracking pipe; a bubble carries "not taken" so that a
  // flushed slot can never raise a second mispredict.
  always_comb begin
    pred_id_d = pred_id_q;
    tgt_id_d  = tgt_id_q;
    pred_ex_d = pred_ex_q;
    tgt_ex_d  = tgt_ex_q;
    if (flush_IFID) begin
      pred_id_d = 1'b0;
      tgt_id_d  = 32'd0;
    end else if (en_IFID) begin
      pred_id_d = predTaken_IF;
      tgt_id_d  = predictedPC;
    end
    if (flush_IDEX) begin
      pred_ex_d = 1'b0;
      tgt_ex_d  = 32'd0;
    end else if (en_IDEX) begin
      pred_ex_d = pred_id_q;
      tgt_ex_d  = tgt_id_q;
    end
  end

  // Tracking registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_id_q <= 1'b0;
      tgt_id_q  <= 32'd0;
      pred_ex_q <= 1'b0;
      tgt_ex_q  <= 32'd0;
    end else begin
      pred_id_q <= pred_id_d;
      tgt_id_q  <= tgt_id_d;
      pred_ex_q <= pred_ex_d;
      tgt_ex_q  <= tgt_ex_d;
    end
  end

  // --------------------------------------------------------------------------
  // EX resolution
  // --------------------------------------------------------------------------
  logic w_dir_miss;
  logic w_tgt_miss;
  logic w_alias_miss;
  logic w_mis;

  assign w_dir_miss   = isBranch_EX & (isTakenBr_Ex != pred_ex_q);
  assign w_tgt_miss   = isBranch_EX & isTakenBr_Ex & pred_ex_q & (PC_Branch != tgt_ex_q);
  // The BTB can alias onto a non-branch; a taken prediction there must be undone.
  assign w_alias_miss = ~isBranch_EX & pred_ex_q;
  assign w_mis        = w_dir_miss | w_tgt_miss | w_alias_miss;

  assign flush_mispredict = w_mis & ~rst;
  assign PC_correct       = (isBranch_EX & isTakenBr_Ex) ? PC_Branch : (PC_EX + 32'd4);
  assign btb_wr_req       = isBranch_EX & isTakenBr_Ex & en_EXMEM & ~rst;

`ifdef BP_STATS_EN
  // --------------------------------------------------------------------------
  // Statistics
  // --------------------------------------------------------------------------
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispredict_cnt_q, mispredict_cnt_d;

  // Count retiring branches and those among them that mispredicted.
  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (w_bht_upd) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
      if (w_mis) mispredict_cnt_d = mispredict_cnt_q + 32'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_q     <= 32'd0;
      mispredict_cnt_q <= 32'd0;
    end else begin
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predict_ctrl
// Purpose  : Self-checking bench for branch_predict_ctrl: directed scenarios
//            followed by randomized traffic, compared every cycle against a
//            behavioural model. Honours BP_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predict_ctrl;

  localparam int AW = 7;
  localparam int N  = 1 << AW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] PC_IF = 32'd0;
  logic        isHit_BTB = 1'b0;
  logic [31:0] predictedPC = 32'd0;
  logic [31:0] NPC_pred;
  logic        predTaken_IF;
  logic        en_IFID = 1'b0, flush_IFID = 1'b0;
  logic        en_IDEX = 1'b0, flush_IDEX = 1'b0;
  logic        en_EXMEM = 1'b0;
  logic        isBranch_EX = 1'b0, isTakenBr_Ex = 1'b0;
  logic [31:0] PC_EX = 32'd0, PC_Branch = 32'd0;
  logic        flush_mispredict;
  logic [31:0] PC_correct;
  logic        btb_wr_req;
`ifdef BP_STATS_EN
  logic [31:0] branch_cnt, mispredict_cnt;
`endif

  always #5 clk = ~clk;

  branch_predict_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .PC_IF            (PC_IF),
    .isHit_BTB        (isHit_BTB),
    .predictedPC      (predictedPC),
    .NPC_pred         (NPC_pred),
    .predTaken_IF     (predTaken_IF),
    .en_IFID          (en_IFID),
    .flush_IFID       (flush_IFID),
    .en_IDEX          (en_IDEX),
    .flush_IDEX       (flush_IDEX),
    .en_EXMEM         (en_EXMEM),
    .isBranch_EX      (isBranch_EX),
    .isTakenBr_Ex     (isTakenBr_Ex),
    .PC_EX            (PC_EX),
    .PC_Branch        (PC_Branch),
    .flush_mispredict (flush_mispredict),
    .PC_correct       (PC_correct),
    .btb_wr_req       (btb_wr_req)
`ifdef BP_STATS_EN
    ,
    .branch_cnt       (branch_cnt),
    .mispredict_cnt   (mispredict_cnt)
`endif
  );

  // --------------------------------------------------------------------------
  // Behavioural model
  // --------------------------------------------------------------------------
  int          m_cnt [N];
  bit          m_pred_id, m_pred_ex;
  logic [31:0] m_tgt_id, m_tgt_ex;
  logic [31:0] m_bcnt, m_mcnt;

  int errors = 0;
  int checks = 0;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = 1;
    m_pred_id = 0; m_pred_ex = 0;
    m_tgt_id  = 0; m_tgt_ex  = 0;
    m_bcnt    = 0; m_mcnt    = 0;
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'(pc[AW+1:2]);
  endfunction

  function automatic bit m_taken_if();
    return isHit_BTB && (m_cnt[idx_of(PC_IF)] >= 2);
  endfunction

  function automatic logic [31:0] m_npc();
    return m_taken_if() ? predictedPC : PC_IF + 32'd4;
  endfunction

  // Prediction is wrong if it claimed a branch that isn't one, guessed the
  // wrong direction, or was taken with the wrong target.
  function automatic bit m_mis();
    if (rst) return 0;
    if (!isBranch_EX) return m_pred_ex;
    if (isTakenBr_Ex != m_pred_ex) return 1;
    return isTakenBr_Ex && (PC_Branch != m_tgt_ex);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial model_reset();

  // Model state advance on each clock edge (and on reset assertion).
  always @(posedge clk or posedge rst) begin : model_step
    bit pt;
    bit mis;
    int ei;
    if (rst) begin
      model_reset();
    end else begin
      pt  = m_taken_if();
      mis = m_mis();
      ei  = idx_of(PC_EX);
      if (isBranch_EX && en_EXMEM) begin
        m_bcnt = m_bcnt + 1;
        if (mis) m_mcnt = m_mcnt + 1;
        if (isTakenBr_Ex) m_cnt[ei] = (m_cnt[ei] == 3) ? 3 : m_cnt[ei] + 1;
        else              m_cnt[ei] = (m_cnt[ei] == 0) ? 0 : m_cnt[ei] - 1;
      end
      if (flush_IDEX) begin
        m_pred_ex = 0; m_tgt_ex = 0;
      end else if (en_IDEX) begin
        m_pred_ex = m_pred_id; m_tgt_ex = m_tgt_id;
      end
      if (flush_IFID) begin
        m_pred_id = 0; m_tgt_id = 0;
      end else if (en_IFID) begin
        m_pred_id = pt; m_tgt_id = predictedPC;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("predTaken_IF", {31'd0, predTaken_IF}, {31'd0, m_taken_if()});
    chk("NPC_pred", NPC_pred, m_npc());
    chk("flush_mispredict", {31'd0, flush_mispredict}, {31'd0, m_mis()});
    if (m_mis())
      chk("PC_correct", PC_correct, (isBranch_EX && isTakenBr_Ex) ? PC_Branch : PC_EX + 32'd4);
    chk("btb_wr_req", {31'd0, btb_wr_req},
        {31'd0, (!rst && isBranch_EX && isTakenBr_Ex && en_EXMEM)});
`ifdef BP_STATS_EN
    chk("branch_cnt", branch_cnt, m_bcnt);
    chk("mispredict_cnt", mispredict_cnt, m_mcnt);
`endif
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ex();
    isBranch_EX = 0; isTakenBr_Ex = 0; en_EXMEM = 0;
    en_IFID = 0; en_IDEX = 0; flush_IFID = 0; flush_IDEX = 0;
  endtask

  function automatic logic [31:0] rand_pc();
    int r;
    r = $urandom_range(0, 11);
    if (r == 11) return 32'hFFFF_FFFC;
    if (r == 10) return 32'h0000_0300;       // aliases 0x100 in the table
    return 32'h100 + 32'(4 * $urandom_range(0, 7));
  endfunction

  initial begin
    // Reset with EX activity present: outputs must stay quiet.
    isBranch_EX = 1; isTakenBr_Ex = 1; en_EXMEM = 1;
    PC_EX = 32'h100; PC_Branch = 32'h200;
    repeat (3) tick();
    chk("rst_btb_wr_req", {31'd0, btb_wr_req}, 32'd0);
    chk("rst_flush", {31'd0, flush_mispredict}, 32'd0);
    rst = 0;
    idle_ex();

    // First lookup: counter is weakly not-taken.
    PC_IF = 32'h100; isHit_BTB = 1; predictedPC = 32'h200;
    #1;
    chk("lit_pred_reset", {31'd0, predTaken_IF}, 32'd0);
    chk("lit_npc_reset", NPC_pred, 32'h104);

    // Two taken retires at 0x100: 01 -> 10 -> 11.
    PC_EX = 32'h100; PC_Branch = 32'h200;
    isBranch_EX = 1; isTakenBr_Ex = 1; en_EXMEM = 1;
    #1;
    chk("lit_btb_wr_1", {31'd0, btb_wr_req}, 32'd1);
    tick();
    chk("lit_btb_wr_2", {31'd0, btb_wr_req}, 32'd1);
    tick();
    idle_ex();
    #1;
    chk("lit_npc_taken", NPC_pred, 32'h200);
    chk("lit_model_cnt3", 32'(m_cnt[64]), 32'd3);

    // Saturation at the bottom, then at the top.
    isBranch_EX = 1; isTakenBr_Ex = 0; en_EXMEM = 1;
    repeat (5) tick();
    chk("lit_model_cnt0", 32'(m_cnt[64]), 32'd0);
    chk("lit_pred_sat0", {31'd0, predTaken_IF}, 32'd0);
    isTakenBr_Ex = 1;
    repeat (2) tick();
    chk("lit_pred_after_2T", {31'd0, predTaken_IF}, 32'd1);
    repeat (3) tick();
    chk("lit_model_sat3", 32'(m_cnt[64]), 32'd3);
    isTakenBr_Ex = 0;
    tick();
    chk("lit_pred_sat3_then_NT", {31'd0, predTaken_IF}, 32'd1);
    idle_ex();

    // Direction mispredict: push a taken prediction into EX.
    en_IFID = 1; tick();
    en_IFID = 0; en_IDEX = 1; tick();
    en_IDEX = 0;
    isBranch_EX = 1; isTakenBr_Ex = 0; PC_EX = 32'h300;
    #1;
    chk("lit_dir_flush", {31'd0, flush_mispredict}, 32'd1);
    chk("lit_dir_pc_correct", PC_correct, 32'h304);
    idle_ex();

    // Target mismatch: predicted 0x400, actual 0x480.
    predictedPC = 32'h400;
    en_IFID = 1; en_IDEX = 1;
    repeat (2) tick();
    en_IFID = 0; en_IDEX = 0;
    isBranch_EX = 1; isTakenBr_Ex = 1; PC_EX = 32'h100; PC_Branch = 32'h480;
    #1;
    chk("lit_tgt_flush", {31'd0, flush_mispredict}, 32'd1);
    chk("lit_tgt_pc_correct", PC_correct, 32'h480);
    PC_Branch = 32'h400;
    #1;
    chk("lit_tgt_match", {31'd0, flush_mispredict}, 32'd0);

    // EX stall on a taken branch: no training, no BTB write.
    en_EXMEM = 0;
    repeat (3) begin
      tick();
      chk("lit_stall_btb", {31'd0, btb_wr_req}, 32'd0);
    end
    chk("lit_stall_model_cnt", 32'(m_cnt[64]), 32'd2);

    // Flush beats enable on ID/EX.
    isBranch_EX = 0; flush_IDEX = 1; en_IDEX = 1;
    tick();
    flush_IDEX = 0; en_IDEX = 0;
    #1;
    chk("lit_bubble_no_flush", {31'd0, flush_mispredict}, 32'd0);

    // One not-taken retire: 10 -> 01 only if the stall left it untouched.
    isBranch_EX = 1; isTakenBr_Ex = 0; en_EXMEM = 1; PC_EX = 32'h100;
    tick();
    idle_ex();
    #1;
    chk("lit_after_stall_NT", {31'd0, predTaken_IF}, 32'd0);

    // Adder wrap at the top of the address space.
    PC_IF = 32'hFFFF_FFFC; isHit_BTB = 0;
    #1;
    chk("lit_npc_wrap", NPC_pred, 32'h0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      tick();
      PC_IF        = rand_pc();
      isHit_BTB    = ($urandom_range(0, 3) != 0);
      predictedPC  = ($urandom_range(0, 1) != 0) ? 32'h200 : $urandom;
      PC_EX        = rand_pc();
      PC_Branch    = ($urandom_range(0, 1) != 0) ? 32'h200 : $urandom;
      isBranch_EX  = ($urandom_range(0, 2) != 0);
      isTakenBr_Ex = ($urandom_range(0, 1) != 0);
      en_EXMEM     = ($urandom_range(0, 3) != 0);
      en_IFID      = ($urandom_range(0, 3) != 0);
      en_IDEX      = ($urandom_range(0, 3) != 0);
      flush_IFID   = ($urandom_range(0, 7) == 0) || (m_mis() && $urandom_range(0, 1) != 0);
      flush_IDEX   = ($urandom_range(0, 7) == 0) || (m_mis() && $urandom_range(0, 1) != 0);
      if (c == 1500) begin
        rst = 1;
        tick();
        rst = 0;
      end
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
